enemy_wave_scheduler: RTL and testbench

//  Upstream driver for the per-lane enemy_control instances. Decides when and in which

---
 rtl/enemy_wave_scheduler_pkg.sv | 16 +
 rtl/enemy_wave_scheduler_lfsr8.sv | 26 ++
 rtl/enemy_wave_scheduler.sv | 165 ++++++++++++++++
 tb/tb_enemy_wave_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_wave_scheduler_pkg.sv
// Shared types and helpers for the enemy wave scheduler: FSM states, LFSR taps,
// counter width and the starting-lane function.
package enemy_wave_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_e;

  // x^8 + x^6 + x^5 + x^4 + 1 as a feedback mask over q[7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int CNT_W = 16;

  function automatic int unsigned lane_start(input logic [7:0] r, input int unsigned n);
    return {24'd0, r} % n;
  endfunction

endpackage

// File: rtl/enemy_wave_scheduler_lfsr8.sv
// 8-bit Fibonacci LFSR; shifts left and feeds the tap parity into bit 0.
module lfsr8
  import enemy_wave_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= seed;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Wave scheduler: picks spawn lanes from an LFSR, paces spawns and the shared
// speed pulse on frame ticks, and freezes on the first base hit until reset.
module enemy_wave_scheduler
  import enemy_wave_scheduler_pkg::*;
#(
  parameter int         N_LANES        = 3,
  parameter int         WAVE_LEN       = 8,
  parameter int         SPAWN_GAP      = 60,
  parameter int         PAUSE_FRAMES   = 120,
  parameter int         SPEED_DIV_INIT = 20,
  parameter int         SPEED_DIV_MIN  = 4,
  parameter int         SPEED_STEP     = 2,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               game_start,
  input  logic [N_LANES-1:0] lane_busy,
  input  logic [N_LANES-1:0] base_hit,
  output logic [N_LANES-1:0] spawn_pulse,
  output logic               speed_pulse,
  output logic [3:0]         wave_num,
  output logic               running
);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam int   LW        = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam cnt_t GAP_RLD   = cnt_t'(SPAWN_GAP);
  localparam cnt_t PAUSE_RLD = cnt_t'(PAUSE_FRAMES);
  localparam cnt_t WLEN      = cnt_t'(WAVE_LEN);
  localparam cnt_t SDIV_INIT = cnt_t'(SPEED_DIV_INIT);
  localparam cnt_t SDIV_MIN  = cnt_t'(SPEED_DIV_MIN);
  localparam cnt_t SDIV_STEP = cnt_t'(SPEED_STEP);

  state_e             state_q, state_d;
  cnt_t               speed_div_q, speed_div_d, speed_cnt_q, speed_cnt_d;
  cnt_t               gap_q, gap_d, pause_q, pause_d, spawn_cnt_q, spawn_cnt_d;
  logic [3:0]         wave_q, wave_d;
  logic [N_LANES-1:0] spawn_q, spawn_d;
  logic               speed_q, speed_d, running_q, running_d;
  logic [7:0]         lfsr_q;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (frame_tick),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Lane pick: start at lfsr % N_LANES, first free lane upward with wrap.
  int unsigned        start_idx;
  logic [LW-1:0]      idx;
  logic               lane_found;
  logic [N_LANES-1:0] lane_oh;

  always_comb begin
    start_idx  = lane_start(lfsr_q, unsigned'(N_LANES));
    lane_found = 1'b0;
    lane_oh    = '0;
    idx        = '0;
    for (int k = 0; k < N_LANES; k++) begin
      idx = LW'((start_idx + unsigned'(k)) % unsigned'(N_LANES));
      if (!lane_found && !lane_busy[idx]) begin
        lane_found   = 1'b1;
        lane_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    speed_div_d = speed_div_q;
    speed_cnt_d = speed_cnt_q;
    gap_d       = gap_q;
    pause_d     = pause_q;
    spawn_cnt_d = spawn_cnt_q;
    wave_d      = wave_q;
    spawn_d     = '0;
    speed_d     = 1'b0;
    unique case (state_q)
      IDLE: if (game_start) begin
        state_d     = RUN;
        wave_d      = 4'd1;
        spawn_cnt_d = '0;
        gap_d       = GAP_RLD;
        speed_cnt_d = speed_div_q - cnt_t'(1);
      end
      RUN, PAUSE: if (|base_hit) begin
        state_d = OVER;
      end else begin
        if (frame_tick) begin
          if (speed_cnt_q == '0) begin
            speed_cnt_d = speed_div_q - cnt_t'(1);
            speed_d     = 1'b1;
          end else begin
            speed_cnt_d = speed_cnt_q - cnt_t'(1);
          end
        end
        if (state_q == RUN) begin
          if (spawn_cnt_q == WLEN) begin
            state_d = PAUSE;
            pause_d = PAUSE_RLD;
          end else if (frame_tick) begin
            gap_d = (gap_q == '0) ? '0 : gap_q - cnt_t'(1);
            // all lanes busy: gap stays at 0 so the next tick retries
            if (gap_d == '0 && lane_found) begin
              spawn_d     = lane_oh;
              spawn_cnt_d = spawn_cnt_q + cnt_t'(1);
              gap_d       = GAP_RLD;
            end
          end
        end else if (frame_tick) begin
          // the tick that takes pause_cnt to zero starts the next wave
          if (pause_q <= cnt_t'(1)) begin
            state_d     = RUN;
            wave_d      = (wave_q == 4'd15) ? wave_q : wave_q + 4'd1;
            speed_div_d = (speed_div_q >= SDIV_MIN + SDIV_STEP) ? speed_div_q - SDIV_STEP
                                                                : SDIV_MIN;
            spawn_cnt_d = '0;
            gap_d       = GAP_RLD;
            pause_d     = '0;
          end else begin
            pause_d = pause_q - cnt_t'(1);
          end
        end
      end
      default: ;
    endcase
    running_d = (state_d == RUN) || (state_d == PAUSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      speed_div_q <= SDIV_INIT;
      speed_cnt_q <= '0;
      gap_q       <= '0;
      pause_q     <= '0;
      spawn_cnt_q <= '0;
      wave_q      <= '0;
      spawn_q     <= '0;
      speed_q     <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      speed_div_q <= speed_div_d;
      speed_cnt_q <= speed_cnt_d;
      gap_q       <= gap_d;
      pause_q     <= pause_d;
      spawn_cnt_q <= spawn_cnt_d;
      wave_q      <= wave_d;
      spawn_q     <= spawn_d;
      speed_q     <= speed_d;
      running_q   <= running_d;
    end
  end

  assign spawn_pulse = spawn_q;
  assign speed_pulse = speed_q;
  assign wave_num    = wave_q;
  assign running     = running_q;

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Randomized bench for enemy_wave_scheduler with an in-bench game model,
// plus hand-computed checkpoints on a deterministic opening.
module tb_enemy_wave_scheduler;

  localparam int N          = 3;
  localparam int WAVE_LEN   = 2;
  localparam int SPAWN_GAP  = 2;
  localparam int PAUSE_FR   = 5;
  localparam int DIV_INIT   = 6;
  localparam int DIV_MIN    = 2;
  localparam int DIV_STEP   = 2;
  localparam logic [7:0] SEED = 8'hA5;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVER = 3;

  logic         clk = 1'b0;
  logic         rst, frame_tick, game_start;
  logic [N-1:0] lane_busy, base_hit, spawn_pulse;
  logic         speed_pulse, running;
  logic [3:0]   wave_num;

  enemy_wave_scheduler #(
    .N_LANES(N), .WAVE_LEN(WAVE_LEN), .SPAWN_GAP(SPAWN_GAP), .PAUSE_FRAMES(PAUSE_FR),
    .SPEED_DIV_INIT(DIV_INIT), .SPEED_DIV_MIN(DIV_MIN), .SPEED_STEP(DIV_STEP), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_start(game_start),
    .lane_busy(lane_busy), .base_hit(base_hit), .spawn_pulse(spawn_pulse),
    .speed_pulse(speed_pulse), .wave_num(wave_num), .running(running)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  int         m_st, m_wave, m_spawns, m_gap, m_spd, m_pause, m_div;
  logic [7:0] m_lfsr;
  logic [N-1:0] exp_spawn;
  logic       exp_speed, exp_run;
  logic [3:0] exp_wave;

  function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int pick(input logic [7:0] r, input logic [N-1:0] busy);
    int s, l, bv;
    s  = int'(r) % N;
    bv = int'(busy);
    for (int k = 0; k < N; k++) begin
      l = (s + k) % N;
      if (((bv >> l) & 1) == 0) return l;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [7:0] pre;
    int lane;
    bit tk;
    tk = frame_tick;
    pre = m_lfsr;
    exp_spawn = '0;
    exp_speed = 1'b0;
    if (tk) m_lfsr = lfsr_adv(m_lfsr);
    case (m_st)
      M_IDLE: if (game_start) begin
        m_st = M_RUN; m_wave = 1; m_spawns = 0; m_gap = SPAWN_GAP; m_spd = m_div - 1;
      end
      M_RUN, M_PAUSE: if (base_hit != 0) begin
        m_st = M_OVER;
      end else begin
        if (tk) begin
          if (m_spd == 0) begin m_spd = m_div - 1; exp_speed = 1'b1; end
          else m_spd--;
        end
        if (m_st == M_RUN) begin
          if (m_spawns == WAVE_LEN) begin
            m_st = M_PAUSE; m_pause = PAUSE_FR;
          end else if (tk) begin
            if (m_gap > 0) m_gap--;
            if (m_gap == 0) begin
              lane = pick(pre, lane_busy);
              if (lane >= 0) begin
                exp_spawn = N'(1 << lane); m_spawns++; m_gap = SPAWN_GAP;
              end
            end
          end
        end else if (tk) begin
          m_pause--;
          if (m_pause <= 0) begin
            m_st = M_RUN; m_spawns = 0; m_gap = SPAWN_GAP;
            m_wave = (m_wave < 15) ? m_wave + 1 : 15;
            m_div = (m_div - DIV_STEP > DIV_MIN) ? m_div - DIV_STEP : DIV_MIN;
          end
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_st = M_IDLE; m_lfsr = SEED; m_div = DIV_INIT; m_wave = 0; m_spawns = 0;
      m_gap = 0; m_spd = 0; m_pause = 0; exp_spawn = '0; exp_speed = 1'b0;
    end else begin
      model_step();
    end
    exp_run  = (m_st == M_RUN) || (m_st == M_PAUSE);
    exp_wave = 4'(m_wave);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("spawn_pulse", 32'(spawn_pulse), 32'(exp_spawn));
      cmp("speed_pulse", 32'(speed_pulse), 32'(exp_speed));
      cmp("wave_num",    32'(wave_num),    32'(exp_wave));
      cmp("running",     32'(running),     32'(exp_run));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst = 1'b1; frame_tick = 1'b0; game_start = 1'b0; lane_busy = '0; base_hit = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    cmp("rst_spawn", 32'(spawn_pulse), 0);
    cmp("rst_speed", 32'(speed_pulse), 0);
    cmp("rst_wave", 32'(wave_num), 0);
    cmp("rst_running", 32'(running), 0);
    rst = 1'b0;

    // Idle: ticks and noise on lane inputs must not start anything
    for (int i = 0; i < 100; i++) begin
      frame_tick = 1'b1; lane_busy = N'($urandom); base_hit = N'($urandom);
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
    cmp("idle_wave", 32'(wave_num), 0);
    cmp("idle_running", 32'(running), 0);
    lane_busy = '0; base_hit = '0;

    // Deterministic opening: start right after reset, so LFSR = A5 at the start
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    game_start = 1'b1; @(negedge clk); game_start = 1'b0;
    cmp("start_running", 32'(running), 1);
    cmp("start_wave", 32'(wave_num), 1);
    for (int t = 1; t <= 16; t++) begin
      if (t == 10) lane_busy = 3'b111;
      if (t == 12) lane_busy = 3'b101;
      frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
      case (t)
        2: begin
          cmp("t2_lane", 32'(spawn_pulse), 32'(3'b100));
          cmp("t2_model_lane", 32'(exp_spawn), 32'(3'b100));
        end
        3: begin
          cmp("t3_no_speed", 32'(speed_pulse), 0);
          cmp("t3_no_spawn", 32'(spawn_pulse), 0);
        end
        4:  cmp("t4_lane", 32'(spawn_pulse), 32'(3'b001));
        6:  cmp("t6_speed", 32'(speed_pulse), 1);
        8:  cmp("t8_wave1", 32'(wave_num), 1);
        9: begin
          cmp("t9_wave2", 32'(wave_num), 2);
          cmp("t9_model_wave2", 32'(exp_wave), 2);
        end
        11: cmp("t11_all_busy", 32'(spawn_pulse), 0);
        12: begin
          cmp("t12_retry_lane1", 32'(spawn_pulse), 32'(3'b010));
          cmp("t12_speed_same_cycle", 32'(speed_pulse), 1);
        end
        15: cmp("t15_no_speed", 32'(speed_pulse), 0);
        16: cmp("t16_speed_div4", 32'(speed_pulse), 1);
        default: ;
      endcase
      @(negedge clk);
    end

    // Random play: ticks at random phases, random occupancy, random start time
    rst = 1'b1; lane_busy = '0; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      frame_tick = ($urandom_range(2) == 0);
      game_start = ($urandom_range(49) == 0);
      lane_busy  = N'($urandom);
      @(negedge clk);
    end
    frame_tick = 1'b0; game_start = 1'b0; lane_busy = '0;

    // Base hit on the very tick a spawn is due
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_st == M_RUN && m_spawns < WAVE_LEN && m_gap <= 1) begin
        found = 1'b1;
      end else begin
        game_start = (m_st == M_IDLE);
        frame_tick = (i % 2 == 0);
        @(negedge clk);
        game_start = 1'b0; frame_tick = 1'b0;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL over_setup: no spawn-due tick reached within 400 cycles");
    end
    frame_tick = 1'b1; base_hit = 3'b100;
    @(negedge clk);
    frame_tick = 1'b0;
    cmp("hit_no_spawn", 32'(spawn_pulse), 0);
    cmp("hit_no_speed", 32'(speed_pulse), 0);
    cmp("hit_running", 32'(running), 0);
    game_start = 1'b1; @(negedge clk); game_start = 1'b0;
    repeat (6) begin
      frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0; @(negedge clk);
    end
    cmp("over_held", 32'(running), 0);
    rst = 1'b1; base_hit = '0; @(negedge clk); rst = 1'b0;
    cmp("over_rst_wave", 32'(wave_num), 0);
    cmp("over_rst_running", 32'(running), 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
